// File: rtl/ni_fifo_wr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// ni_fifo_wr_arbiter
//------------------------------------------------------------------------------
// Round-robin packet arbiter in front of the network-interface FIFO write
// channel. The grant is held until a requester's last beat is accepted, so
// packets are never interleaved. A per-grant beat limit forces a release
// when a requester never ends its packet.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module ni_fifo_wr_arbiter #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_REQ    = 4,
   parameter int MAX_BEATS  = 16
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic [NUM_REQ-1:0]              s_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0]   s_data,
   input  logic [NUM_REQ-1:0]              s_last,
   output logic [NUM_REQ-1:0]              s_ready,
   output logic                            m_valid,
   output logic [DATA_WIDTH-1:0]           m_data,
   output logic                            m_last,
   output logic [$clog2(NUM_REQ)-1:0]      m_id,
   input  logic                            m_ready,
   output logic                            busy,
   output logic                            err_long
);

   localparam int ID_W  = $clog2(NUM_REQ);
   localparam int CNT_W = $clog2(MAX_BEATS + 1);

   // Beat index at which the grant is forcibly released.
   localparam logic [CNT_W-1:0] c_BEAT_LIMIT = CNT_W'(MAX_BEATS - 1);
   // Pointer value after reset; makes requester 0 the first winner.
   localparam logic [ID_W-1:0]  c_LAST_INIT  = ID_W'(NUM_REQ - 1);

   localparam logic [0:0] c_IDLE  = 1'b0;
   localparam logic [0:0] c_GRANT = 1'b1;

   logic [0:0]            r_state;
   logic [0:0]            w_state_nxt;
   logic [ID_W-1:0]       r_grant;
   logic [ID_W-1:0]       r_last_grant;
   logic [CNT_W-1:0]      r_beat_cnt;
   logic                  r_err_long;

   logic [DATA_WIDTH-1:0] w_data_arr [NUM_REQ];
   logic                  w_pick_vld;
   logic [ID_W-1:0]       w_pick_idx;
   logic                  w_in_grant;
   logic                  w_cur_valid;
   logic                  w_cur_last;
   logic                  w_at_limit;
   logic                  w_accept;
   logic                  w_release;
   logic                  w_force;

   // Wrap a requester offset into the valid index range.
   function automatic logic [ID_W-1:0] f_wrap(input int v);
      return ID_W'(v % NUM_REQ);
   endfunction

   // Split the flat data bus into one beat per requester.
   generate
      for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
         assign w_data_arr[gi] = s_data[gi*DATA_WIDTH +: DATA_WIDTH];
      end
   endgenerate

   // Rotating-priority search starting just after the last granted requester.
   // Scanning from the farthest offset down lets the nearest valid one win.
   always_comb begin
      w_pick_vld = 1'b0;
      w_pick_idx = '0;
      for (int k = NUM_REQ; k >= 1; k--) begin
         if (s_valid[f_wrap(int'(r_last_grant) + k)]) begin
            w_pick_vld = 1'b1;
            w_pick_idx = f_wrap(int'(r_last_grant) + k);
         end
      end
   end

   assign w_in_grant  = (r_state == c_GRANT);
   assign w_cur_valid = s_valid[r_grant];
   assign w_cur_last  = s_last[r_grant];
   assign w_at_limit  = (r_beat_cnt == c_BEAT_LIMIT);
   assign w_accept    = w_in_grant & w_cur_valid & m_ready;
   // A beat that ends the packet or hits the limit closes the grant.
   assign w_release   = w_accept & (w_cur_last | w_at_limit);
   // A genuine last beat on the limit beat is a normal end, not an error.
   assign w_force     = w_accept & w_at_limit & ~w_cur_last;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= c_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Next-state logic: one arbitration cycle in IDLE, hold GRANT until release.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         c_IDLE:  if (w_pick_vld) w_state_nxt = c_GRANT;
         c_GRANT: if (w_release)  w_state_nxt = c_IDLE;
         default: w_state_nxt = c_IDLE;
      endcase
   end

   // Grant pointer, rotation pointer, beat counter and timeout pulse.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_grant      <= '0;
         r_last_grant <= c_LAST_INIT;
         r_beat_cnt   <= '0;
         r_err_long   <= 1'b0;
      end else begin
         r_err_long <= w_force;
         if (r_state == c_IDLE) begin
            if (w_pick_vld) begin
               r_grant    <= w_pick_idx;
               r_beat_cnt <= '0;
            end
         end else if (w_accept) begin
            r_beat_cnt <= r_beat_cnt + 1'b1;
            if (w_release) begin
               r_last_grant <= r_grant;
            end
         end
      end
   end

   // Output logic: pass the granted requester straight through, zero latency.
   always_comb begin
      s_ready = '0;
      m_valid = 1'b0;
      m_data  = '0;
      m_last  = 1'b0;
      m_id    = '0;
      busy    = 1'b0;
      if (w_in_grant) begin
         busy             = 1'b1;
         m_id             = r_grant;
         m_valid          = w_cur_valid;
         m_data           = w_data_arr[r_grant];
         m_last           = w_cur_last | w_at_limit;
         s_ready[r_grant] = m_ready;
      end
   end

   assign err_long = r_err_long;

endmodule
`default_nettype wire

// File: tb/tb_ni_fifo_wr_arbiter.sv
`default_nettype none
//------------------------------------------------------------------------------
// tb_ni_fifo_wr_arbiter
//------------------------------------------------------------------------------
// Directed bench for the round-robin packet arbiter. Inputs change on the
// falling edge; outputs are compared 1 ns later, well before the rising edge.
//------------------------------------------------------------------------------
// Revision: 1.0 - initial release
//------------------------------------------------------------------------------
module tb_ni_fifo_wr_arbiter;

   localparam int DW  = 8;
   localparam int NR  = 4;
   localparam int MB  = 16;
   localparam int IDW = 2;

   logic              clk = 1'b0;
   logic              rst_n;
   logic [NR-1:0]     s_valid;
   logic [NR*DW-1:0]  s_data;
   logic [NR-1:0]     s_last;
   logic [NR-1:0]     s_ready;
   logic              m_valid;
   logic [DW-1:0]     m_data;
   logic              m_last;
   logic [IDW-1:0]    m_id;
   logic              m_ready;
   logic              busy;
   logic              err_long;

   int n_vec = 0;
   int n_err = 0;

   ni_fifo_wr_arbiter #(
      .DATA_WIDTH (DW),
      .NUM_REQ    (NR),
      .MAX_BEATS  (MB)
   ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .s_valid  (s_valid),
      .s_data   (s_data),
      .s_last   (s_last),
      .s_ready  (s_ready),
      .m_valid  (m_valid),
      .m_data   (m_data),
      .m_last   (m_last),
      .m_id     (m_id),
      .m_ready  (m_ready),
      .busy     (busy),
      .err_long (err_long)
   );

   always #5 clk = ~clk;

   // Guard against a run that never reaches the summary.
   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic set_req(input int i, input logic v, input logic [DW-1:0] d, input logic l);
      s_valid[i]          = v;
      s_data[i*DW +: DW]  = d;
      s_last[i]           = l;
   endtask

   task automatic step();
      @(negedge clk);
   endtask

   // Expect a valid beat from requester id with the given data/last.
   task automatic chk_beat(input string tag, input int id, input logic [DW-1:0] d,
                           input logic l, input logic rdy);
      logic [NR-1:0] exp_rdy;
      exp_rdy     = '0;
      exp_rdy[id] = rdy;
      chk({tag, "_valid"}, 32'(m_valid), 32'd1);
      chk({tag, "_id"},    32'(m_id),    32'(id));
      chk({tag, "_data"},  32'(m_data),  32'(d));
      chk({tag, "_last"},  32'(m_last),  32'(l));
      chk({tag, "_ready"}, 32'(s_ready), 32'(exp_rdy));
      chk({tag, "_busy"},  32'(busy),    32'd1);
   endtask

   // Expect the re-arbitration / idle cycle.
   task automatic chk_idle(input string tag, input logic err);
      chk({tag, "_valid"}, 32'(m_valid),  32'd0);
      chk({tag, "_ready"}, 32'(s_ready),  32'd0);
      chk({tag, "_busy"},  32'(busy),     32'd0);
      chk({tag, "_err"},   32'(err_long), 32'(err));
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_ready"}, 32'(s_ready),  32'd0);
      chk({tag, "_valid"}, 32'(m_valid),  32'd0);
      chk({tag, "_data"},  32'(m_data),   32'd0);
      chk({tag, "_last"},  32'(m_last),   32'd0);
      chk({tag, "_id"},    32'(m_id),     32'd0);
      chk({tag, "_busy"},  32'(busy),     32'd0);
      chk({tag, "_err"},   32'(err_long), 32'd0);
   endtask

   initial begin
      logic rdy_seq [6];
      int   b;

      rst_n   = 1'b0;
      s_valid = '0;
      s_data  = '0;
      s_last  = '0;
      m_ready = 1'b1;
      step(); step(); #1;
      chk_all_zero("rst");
      step();
      rst_n = 1'b1;
      #1;

      // 1: all requesters, single-beat packets -> ids 0,1,2,3,0 with bubbles
      step();
      for (int i = 0; i < NR; i++) set_req(i, 1'b1, 8'h10 + 8'(i), 1'b1);
      #1; chk_idle("t1_idle", 1'b0);
      for (int k = 0; k < 5; k++) begin
         step(); #1; chk_beat("t1_beat", k % NR, 8'h10 + 8'(k % NR), 1'b1, 1'b1);
         step(); #1; chk_idle("t1_gap", 1'b0);
      end
      s_valid = '0;

      // 2: req2 three-beat packet while req0 waits; req0 served next
      step();
      set_req(2, 1'b1, 8'hA0, 1'b0);
      set_req(0, 1'b1, 8'h50, 1'b1);
      #1; chk_idle("t2_idle", 1'b0);
      step(); #1; chk_beat("t2_a0", 2, 8'hA0, 1'b0, 1'b1);
      step(); set_req(2, 1'b1, 8'hA1, 1'b0); #1; chk_beat("t2_a1", 2, 8'hA1, 1'b0, 1'b1);
      step(); set_req(2, 1'b1, 8'hA2, 1'b1); #1; chk_beat("t2_a2", 2, 8'hA2, 1'b1, 1'b1);
      step(); set_req(2, 1'b0, 8'h00, 1'b0); #1; chk_idle("t2_gap", 1'b0);
      step(); #1; chk_beat("t2_r0", 0, 8'h50, 1'b1, 1'b1);
      step(); s_valid = '0; #1; chk_idle("t2_end", 1'b0);

      // 3: back-pressure during a four-beat packet from req1
      rdy_seq = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
      step();
      set_req(1, 1'b1, 8'hB0, 1'b0);
      #1; chk_idle("t3_idle", 1'b0);
      b = 0;
      for (int j = 0; j < 6; j++) begin
         step();
         m_ready = rdy_seq[j];
         set_req(1, 1'b1, 8'hB0 + 8'(b), (b == 3));
         #1; chk_beat("t3_beat", 1, 8'hB0 + 8'(b), (b == 3), rdy_seq[j]);
         if (rdy_seq[j]) b++;
      end
      step(); set_req(1, 1'b0, 8'h00, 1'b0); m_ready = 1'b1;
      #1; chk_idle("t3_end", 1'b0);

      // 4: req1 runs past the beat limit; req3 gets its turn in between
      step();
      set_req(1, 1'b1, 8'h80, 1'b0);
      #1; chk_idle("t4_idle", 1'b0);
      for (int n = 0; n < MB; n++) begin
         step();
         set_req(1, 1'b1, 8'h80 + 8'(n), 1'b0);
         if (n == 0) set_req(3, 1'b1, 8'h33, 1'b1);
         #1; chk_beat("t4_beat", 1, 8'h80 + 8'(n), (n == MB - 1), 1'b1);
      end
      step(); #1; chk_idle("t4_force", 1'b1);
      step(); #1; chk_beat("t4_r3", 3, 8'h33, 1'b1, 1'b1);
      chk("t4_err_clr", 32'(err_long), 32'd0);
      step();
      set_req(3, 1'b0, 8'h00, 1'b0);
      set_req(1, 1'b1, 8'h90, 1'b0);
      #1; chk_idle("t4_gap", 1'b0);
      for (int n = 16; n < 20; n++) begin
         step();
         set_req(1, 1'b1, 8'h80 + 8'(n), (n == 19));
         #1; chk_beat("t4_rest", 1, 8'h80 + 8'(n), (n == 19), 1'b1);
      end
      step(); set_req(1, 1'b0, 8'h00, 1'b0); #1; chk_idle("t4_end", 1'b0);

      // 5: reset in the middle of a five-beat packet from req0
      step();
      set_req(0, 1'b1, 8'hC0, 1'b0);
      #1; chk_idle("t5_idle", 1'b0);
      step(); #1; chk_beat("t5_c0", 0, 8'hC0, 1'b0, 1'b1);
      step(); set_req(0, 1'b1, 8'hC1, 1'b0); #1; chk_beat("t5_c1", 0, 8'hC1, 1'b0, 1'b1);
      step(); set_req(0, 1'b1, 8'hC2, 1'b0); #1; chk_beat("t5_c2", 0, 8'hC2, 1'b0, 1'b1);
      rst_n = 1'b0;
      #1; chk_all_zero("t5_rst");
      set_req(0, 1'b1, 8'h60, 1'b1);
      set_req(2, 1'b1, 8'h22, 1'b1);
      step(); step();
      rst_n = 1'b1;
      #1; chk_idle("t5_rel", 1'b0);
      step(); #1; chk_beat("t5_first", 0, 8'h60, 1'b1, 1'b1);
      step(); s_valid = '0; #1; chk_idle("t5_end", 1'b0);

      // 6: genuine last beat lands exactly on the beat limit
      step();
      set_req(2, 1'b1, 8'hE0, 1'b0);
      #1; chk_idle("t6_idle", 1'b0);
      for (int n = 0; n < MB; n++) begin
         step();
         set_req(2, 1'b1, 8'hE0 + 8'(n), (n == MB - 1));
         #1; chk_beat("t6_beat", 2, 8'hE0 + 8'(n), (n == MB - 1), 1'b1);
      end
      step(); set_req(2, 1'b0, 8'h00, 1'b0); #1; chk_idle("t6_noerr", 1'b0);
      step(); #1; chk_idle("t6_end", 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire
